// File: rtl/sc_decode_pkg.sv
// sc_decode_pkg: shared definitions for the stochastic-to-binary decoder.
//   - sc_state_e        : decoder FSM states (IDLE, ACC, HOLD)
//   - SC_DEFAULT_CWIDTH : default window exponent / output width
//   - sat_unipolar()    : clamps a ones count to the largest CWIDTH-bit value
package sc_decode_pkg;

    localparam int unsigned SC_DEFAULT_CWIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        HOLD
    } sc_state_e;

    // A full window of ones yields 2^width, which does not fit in width bits;
    // clamp it to all-ones. Valid for width up to 31.
    function automatic logic [31:0] sat_unipolar(input logic [31:0] count,
                                                 input int unsigned width);
        logic [31:0] max_val;
        max_val = (32'd1 << width) - 32'd1;
        return (count > max_val) ? max_val : count;
    endfunction

endpackage

// File: rtl/sc_window_counter.sv
// sc_window_counter: counts valid samples within one decode window.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr      : zero the counter (takes priority over en)
//   en       : count one sample this cycle
//   tc       : counter holds 2^CWIDTH-1, i.e. the next enabled sample
//              completes the window
module sc_window_counter #(
    parameter int unsigned CWIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CWIDTH:0] LAST_IDX = {1'b0, {CWIDTH{1'b1}}};

    logic [CWIDTH:0] cnt_q;
    logic [CWIDTH:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == LAST_IDX);

endmodule

// File: rtl/sc_bitstream_decoder.sv
// sc_bitstream_decoder: counts the ones of a unipolar stochastic bitstream
// over 2^CWIDTH valid samples and offers the result on a valid/ready port.
// Optional build macro: SC2BIN_BIPOLAR_EN selects two's-complement bipolar
// output (count - 2^(CWIDTH-1), saturated at the top); default is unipolar.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start     : begin a new window (honoured in IDLE, or in HOLD on accept)
//   in_valid  : bit_in carries a sample this cycle
//   bit_in    : stochastic sample
//   busy      : high while in ACC or HOLD
//   out_valid : result held and waiting for out_ready
//   out_ready : consumer accepts the result
//   value     : decoded result, retained after acceptance
module sc_bitstream_decoder
    import sc_decode_pkg::*;
#(
    parameter int unsigned CWIDTH = SC_DEFAULT_CWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic              bit_in,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CWIDTH-1:0] value
);

    sc_state_e         state_q, state_d;
    logic [CWIDTH:0]   ones_q, ones_d;
    logic [CWIDTH-1:0] value_q, value_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;

    logic              win_clr;
    logic              win_en;
    logic              win_tc;
    logic [CWIDTH:0]   ones_sum;
    logic [CWIDTH-1:0] result_enc;

`ifdef SC2BIN_BIPOLAR_EN
    localparam logic [CWIDTH-1:0] SIGN_BIT = {1'b1, {(CWIDTH-1){1'b0}}};
`endif

    sc_window_counter #(
        .CWIDTH (CWIDTH)
    ) u_window_counter (
        .clk (clk),
        .rst (rst),
        .clr (win_clr),
        .en  (win_en),
        .tc  (win_tc)
    );

    assign win_en   = in_valid && (state_q == ACC);
    assign ones_sum = ones_q + (CWIDTH+1)'(bit_in);

    // Bipolar offset of 2^(CWIDTH-1) on the saturated count is just an MSB
    // flip, and the unipolar clamp at 2^CWIDTH-1 gives the +2^(CWIDTH-1)-1 cap.
    always_comb begin
        result_enc = CWIDTH'(sat_unipolar(32'(ones_sum), CWIDTH));
`ifdef SC2BIN_BIPOLAR_EN
        result_enc = result_enc ^ SIGN_BIT;
`endif
    end

    always_comb begin
        state_d     = state_q;
        ones_d      = ones_q;
        value_d     = value_q;
        out_valid_d = out_valid_q;
        win_clr     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACC;
                    ones_d  = '0;
                    win_clr = 1'b1;
                end
            end
            ACC: begin
                if (in_valid) begin
                    ones_d = ones_sum;
                    if (win_tc) begin
                        state_d     = HOLD;
                        value_d     = result_enc;
                        out_valid_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (start) begin
                        state_d = ACC;
                        ones_d  = '0;
                        win_clr = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ones_q      <= '0;
            value_q     <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ones_q      <= ones_d;
            value_q     <= value_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign value     = value_q;

endmodule

// File: tb/tb_sc_bitstream_decoder.sv
// tb_sc_bitstream_decoder: directed self-checking bench for
// sc_bitstream_decoder at CWIDTH=8 (unipolar or SC2BIN_BIPOLAR_EN build).
module tb_sc_bitstream_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic       bit_in;
    logic       busy;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] value;

    int checks = 0;
    int errors = 0;

    // Outputs observed just after the first edge of the latest run_window
    logic first_busy;
    logic first_out_valid;

`ifdef SC2BIN_BIPOLAR_EN
    localparam logic [7:0] EXP_ONES   = 8'd127;
    localparam logic [7:0] EXP_ZEROS  = 8'h80;
    localparam logic [7:0] EXP_ALT    = 8'h00;
    localparam logic [7:0] EXP_SPARSE = 8'd127;
    localparam logic [7:0] EXP_JUNK   = 8'h00;
`else
    localparam logic [7:0] EXP_ONES   = 8'd255;
    localparam logic [7:0] EXP_ZEROS  = 8'd0;
    localparam logic [7:0] EXP_ALT    = 8'd128;
    localparam logic [7:0] EXP_SPARSE = 8'd255;
    localparam logic [7:0] EXP_JUNK   = 8'd128;
`endif

    sc_bitstream_decoder #(
        .CWIDTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .bit_in    (bit_in),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .value     (value)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issues start (with out_ready if ready_first) and feeds samples until
    // out_valid rises. edges counts clock edges from the start edge inclusive.
    // Modes: 0 all ones, 1 all zeros, 2 alternating 1/0,
    //        3 valid on even cycles with bit=1 there,
    //        4 valid on even cycles, bit=1 on invalid cycles, alternating on valid.
    task automatic run_window(input int mode, input logic ready_first,
                              input logic mid_start, output int edges,
                              output logic timed_out);
        int i;
        start     = 1'b1;
        out_ready = ready_first;
        in_valid  = 1'b0;
        bit_in    = 1'b0;
        tick();
        first_busy      = busy;
        first_out_valid = out_valid;
        edges     = 1;
        i         = 1;
        timed_out = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        while (out_valid !== 1'b1) begin
            if (edges >= 1200) begin
                timed_out = 1'b1;
                break;
            end
            case (mode)
                0: begin in_valid = 1'b1; bit_in = 1'b1; end
                1: begin in_valid = 1'b1; bit_in = 1'b0; end
                2: begin in_valid = 1'b1; bit_in = (i % 2 == 1); end
                3: begin in_valid = (i % 2 == 0); bit_in = (i % 2 == 0); end
                default: begin
                    in_valid = (i % 2 == 0);
                    bit_in   = (i % 2 == 0) ? (i % 4 == 0) : 1'b1;
                end
            endcase
            start = mid_start && (i == 100);
            tick();
            edges++;
            i++;
        end
        in_valid = 1'b0;
        bit_in   = 1'b0;
        start    = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || value !== 8'd0) begin
            errors++;
            $display("FAIL reset: busy=%b out_valid=%b value=%0d expected 0 0 0",
                     busy, out_valid, value);
        end
    endtask

    task automatic test_all_ones;
        int   edges;
        logic to;
        run_window(0, 1'b0, 1'b0, edges, to);
        checks++;
        if (first_busy !== 1'b1) begin
            errors++;
            $display("FAIL ones_busy: got %b expected 1", first_busy);
        end
        checks++;
        if (to || edges != 257) begin
            errors++;
            $display("FAIL ones_latency: got %0d (timeout=%b) expected 257", edges, to);
        end
        checks++;
        if (value !== EXP_ONES) begin
            errors++;
            $display("FAIL ones_value: got %0d expected %0d", value, EXP_ONES);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ones_accept: out_valid=%b busy=%b expected 0 0", out_valid, busy);
        end
        checks++;
        if (value !== EXP_ONES) begin
            errors++;
            $display("FAIL ones_retain: got %0d expected %0d", value, EXP_ONES);
        end
    endtask

    task automatic test_all_zeros;
        int   edges;
        logic to;
        run_window(1, 1'b0, 1'b0, edges, to);
        checks++;
        if (to || edges != 257 || value !== EXP_ZEROS) begin
            errors++;
            $display("FAIL zeros: edges=%0d value=%0d expected 257 %0d", edges, value, EXP_ZEROS);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_alternating;
        int   edges;
        logic to;
        run_window(2, 1'b0, 1'b0, edges, to);
        checks++;
        if (to || edges != 257 || value !== EXP_ALT) begin
            errors++;
            $display("FAIL alternating: edges=%0d value=%0d expected 257 %0d", edges, value, EXP_ALT);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_sparse_valid;
        int   edges;
        logic to;
        run_window(3, 1'b0, 1'b0, edges, to);
        checks++;
        if (to || edges != 513) begin
            errors++;
            $display("FAIL sparse_latency: got %0d (timeout=%b) expected 513", edges, to);
        end
        checks++;
        if (value !== EXP_SPARSE) begin
            errors++;
            $display("FAIL sparse_value: got %0d expected %0d", value, EXP_SPARSE);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        run_window(4, 1'b0, 1'b0, edges, to);
        checks++;
        if (to || edges != 513 || value !== EXP_JUNK) begin
            errors++;
            $display("FAIL invalid_bits_ignored: edges=%0d value=%0d expected 513 %0d",
                     edges, value, EXP_JUNK);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        int   edges;
        logic to;
        run_window(0, 1'b0, 1'b0, edges, to);
        for (int k = 0; k < 20; k++) begin
            start    = (k % 5 == 2);
            in_valid = 1'b1;
            bit_in   = 1'b0;
            tick();
            checks++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || value !== EXP_ONES) begin
                errors++;
                $display("FAIL hold_stable[%0d]: out_valid=%b busy=%b value=%0d expected 1 1 %0d",
                         k, out_valid, busy, value, EXP_ONES);
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;
        // Accept and restart on the same edge; a start mid-window is ignored.
        run_window(1, 1'b1, 1'b1, edges, to);
        checks++;
        if (first_busy !== 1'b1 || first_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_restart: busy=%b out_valid=%b expected 1 0",
                     first_busy, first_out_valid);
        end
        checks++;
        if (to || edges != 257 || value !== EXP_ZEROS) begin
            errors++;
            $display("FAIL b2b_window: edges=%0d value=%0d expected 257 %0d", edges, value, EXP_ZEROS);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_mid_reset;
        int   edges;
        logic to;
        run_window(0, 1'b0, 1'b0, edges, to);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        start = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        bit_in   = 1'b1;
        for (int k = 0; k < 100; k++) tick();
        rst = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || value !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b out_valid=%b value=%0d expected 0 0 0",
                     busy, out_valid, value);
        end
        rst = 1'b0;
        // Samples offered while idle must not be counted.
        for (int k = 0; k < 3; k++) tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b expected 0", busy);
        end
        run_window(2, 1'b0, 1'b0, edges, to);
        checks++;
        if (to || edges != 257 || value !== EXP_ALT) begin
            errors++;
            $display("FAIL post_reset_window: edges=%0d value=%0d expected 257 %0d",
                     edges, value, EXP_ALT);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        bit_in    = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_all_ones();
        test_all_zeros();
        test_alternating();
        test_sparse_valid();
        test_back_to_back();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sc_bitstream_decoder.md
# sc_bitstream_decoder

Stochastic-to-binary decoder: accumulates the ones of a unipolar stochastic bitstream over a fixed window of 2^CWIDTH valid samples and presents the resulting binary value on a valid/ready output port. It is the consuming end of the stochastic datapath. It sits after stochastic compute units such as the correlated divider and returns their bitstream results to the binary domain for readout or for re-encoding by a comparator-based generator.

## Interface
- CWIDTH, default 8: window is 2^CWIDTH valid samples; output value width.
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  single-cycle request to begin a new window.
- in_valid  input  1  bit_in is a sample this cycle.
- bit_in  input  1  stochastic bitstream sample.
- busy  output  1  high in ACC and HOLD.
- out_valid  output  1  result available (HOLD state).
- out_ready  input  1  consumer accepts result.
- value  output  CWIDTH  decoded result.

## Operation
- FSM states: IDLE, ACC, HOLD. Reset: state IDLE, internal ones counter 0, window counter 0, busy 0, out_valid 0, value 0.
- IDLE, start=1: clear both counters, go to ACC. start=0: stay.
- ACC: each cycle with in_valid=1, window counter +1 and ones counter +bit_in. Samples with in_valid=0 are ignored.
- ACC, on the cycle the 2^CWIDTH-th valid sample is taken: go to HOLD. value is latched from the ones count including that sample.
- Ones counter is CWIDTH+1 bits wide (range 0..2^CWIDTH).
  - Unipolar value = min(count, 2^CWIDTH-1).
  - An all-ones window saturates to all-ones.
- HOLD: value and out_valid are stable until out_ready=1. On accept, go to IDLE. If start=1 in the same cycle as accept, go directly to ACC with counters cleared.
- start is ignored in ACC, and in HOLD without out_ready. No restart mid-window.
- in_valid in IDLE and HOLD is ignored. Samples are dropped, not buffered.
- value retains the last result after acceptance, until the next HOLD entry or reset.
- rst mid-window or in HOLD has immediate effect: state IDLE, all outputs 0, the partial window is discarded.

## Timing
- start sampled at edge t: busy=1 from t+1. The first countable sample is at edge t+1.
- Final valid sample at edge k: out_valid=1 and value updated from k+1.
- Minimum latency is start to out_valid = 2^CWIDTH + 1 cycles, when in_valid is held high.
- Accept at edge a (out_valid & out_ready): out_valid=0 from a+1.
- Back-to-back throughput is one window per 2^CWIDTH + 1 cycles, using start coincident with accept.
- No combinational path from inputs to outputs. All outputs are registered.

## Configuration
- SC2BIN_BIPOLAR_EN defined:
  - value is two's-complement bipolar: count - 2^(CWIDTH-1).
  - Saturated to +2^(CWIDTH-1)-1 at the top.
  - Range is -2^(CWIDTH-1)..+2^(CWIDTH-1)-1.
  - The reset value stays 0.
- Not defined: unipolar encoding only, as above. No bipolar logic is present.

## Structure
- Package sc_decode_pkg holds:
  - the FSM state enum (IDLE, ACC, HOLD);
  - the saturation helper function;
  - the default CWIDTH constant.
- One sub-module, sc_window_counter. It holds the CWIDTH+1-bit window counter with clear, enable (in_valid & in ACC) and a terminal-count flag. The top instantiates it and holds the FSM, ones counter and output register.

## Test plan
- CWIDTH=8, in_valid=1, bit_in=1 for the whole window -> out_valid at start+257, value=255 (saturated). With SC2BIN_BIPOLAR_EN, value=127.
- bit_in all zeros -> value=0. With SC2BIN_BIPOLAR_EN, value=-128 (0x80).
- Alternating 1/0 bit_in -> value=128. With SC2BIN_BIPOLAR_EN, value=0.
- in_valid high every other cycle, bit_in=1 on valid cycles only -> out_valid at start+513, value=255. Invalid-cycle bits do not change the count.
- Backpressure: out_ready=0 for 20 cycles after HOLD entry -> value and out_valid stable. Extra start pulses are ignored. out_ready=1 together with start -> new window begins and busy stays 1.
- rst asserted 100 cycles into a window -> next cycle all outputs 0 and state IDLE. A new start yields a full 2^CWIDTH-sample window result with no residue.
